// File: rtl/rhythm_pkg.sv
// rtl/rhythm_pkg.sv - shared states and keycodes for the rhythm game score path
package rhythm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [7:0] KEY_START   = 8'h2c;
   localparam logic [7:0] KEY_RESTART = 8'h01;

   localparam int COMBO_BONUS_THRESH = 10;

endpackage

// File: rtl/drop_score_tally_if.sv
// rtl/drop_score_tally_if.sv - lane levels, keycode and score outputs of the tally
interface drop_score_tally_if #(
   parameter int N_LANES = 16,
   parameter int SCORE_W = 16,
   parameter int CNT_W   = 8
);
   logic [7:0]         keycode;
   logic [N_LANES-1:0] hit;
   logic [N_LANES-1:0] done;
   logic [SCORE_W-1:0] score;
   logic [CNT_W-1:0]   combo;
   logic [CNT_W-1:0]   max_combo;
   logic [CNT_W-1:0]   hits;
   logic [CNT_W-1:0]   misses;
   logic               game_over;

   modport master (
      output keycode, hit, done,
      input  score, combo, max_combo, hits, misses, game_over
   );

   modport slave (
      input  keycode, hit, done,
      output score, combo, max_combo, hits, misses, game_over
   );
endinterface

// File: rtl/lane_popcount.sv
// rtl/lane_popcount.sv - combinational population count over the lane mask
module lane_popcount #(
   parameter int N_LANES = 16
) (
   input  logic [N_LANES-1:0]             lanes,
   output logic [$clog2(N_LANES+1)-1:0]   count
);
   localparam int CW = $clog2(N_LANES + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < N_LANES; i++) begin
         count = count + CW'(lanes[i]);
      end
   end
endmodule

// File: rtl/drop_score_tally.sv
// rtl/drop_score_tally.sv - counts each lane's note once as hit or miss; COMBO_BONUS_EN doubles points on long combos
module drop_score_tally
   import rhythm_pkg::*;
#(
   parameter int N_LANES    = 16,
   parameter int SCORE_W    = 16,
   parameter int CNT_W      = 8,
   parameter int HIT_POINTS = 100
) (
   input  logic              frame_clk,
   input  logic              Reset_n,
   drop_score_tally_if.slave bus
);
   localparam int PW = $clog2(N_LANES + 1);

   state_t             state, state_n;
   logic [N_LANES-1:0] hit_q, done_q, resolved, resolved_n;
   logic [N_LANES-1:0] new_hit, new_miss;
   logic [PW-1:0]      nh, nm;

   logic [SCORE_W-1:0] score_r, score_n;
   logic [CNT_W-1:0]   combo_r, combo_n, max_r, max_n;
   logic [CNT_W-1:0]   hits_r, hits_n, misses_r, misses_n;
   logic               over_r;

   logic [31:0]        pts;
   logic [32:0]        score_sum;
   logic [CNT_W:0]     hits_sum, misses_sum, combo_sum;
   logic [CNT_W-1:0]   combo_sat;

   // A lane with hit and done rising together is a hit, never a miss.
   always_comb begin
      new_hit  = '0;
      new_miss = '0;
      if (state == PLAY) begin
         new_hit  = bus.hit & ~hit_q & ~resolved;
         new_miss = bus.done & ~done_q & ~resolved & ~bus.hit;
      end
   end

   lane_popcount #(.N_LANES(N_LANES)) u_nh (.lanes(new_hit),  .count(nh));
   lane_popcount #(.N_LANES(N_LANES)) u_nm (.lanes(new_miss), .count(nm));

   always_comb begin
      pts = 32'(HIT_POINTS);
`ifdef COMBO_BONUS_EN
      if (32'(combo_r) >= 32'(COMBO_BONUS_THRESH)) begin
         pts = 32'(2 * HIT_POINTS);
      end
`endif
      score_sum  = 33'(score_r) + 33'(32'(nh) * pts);
      hits_sum   = {1'b0, hits_r} + (CNT_W+1)'(nh);
      misses_sum = {1'b0, misses_r} + (CNT_W+1)'(nm);
      // Misses in a cycle break the combo before that cycle's hits are added.
      combo_sum  = (nm != '0) ? (CNT_W+1)'(nh) : ({1'b0, combo_r} + (CNT_W+1)'(nh));
      combo_sat  = combo_sum[CNT_W] ? '1 : combo_sum[CNT_W-1:0];
   end

   always_comb begin
      state_n    = state;
      resolved_n = resolved;
      score_n    = score_r;
      combo_n    = combo_r;
      max_n      = max_r;
      hits_n     = hits_r;
      misses_n   = misses_r;
      unique case (state)
         IDLE: begin
            resolved_n = '0;
            score_n    = '0;
            combo_n    = '0;
            max_n      = '0;
            hits_n     = '0;
            misses_n   = '0;
            if (bus.keycode == KEY_START) state_n = PLAY;
         end
         PLAY: begin
            resolved_n = resolved | new_hit | new_miss;
            score_n    = (score_sum > {{(33-SCORE_W){1'b0}}, {SCORE_W{1'b1}}})
                       ? '1 : score_sum[SCORE_W-1:0];
            hits_n     = hits_sum[CNT_W]   ? '1 : hits_sum[CNT_W-1:0];
            misses_n   = misses_sum[CNT_W] ? '1 : misses_sum[CNT_W-1:0];
            combo_n    = combo_sat;
            max_n      = (combo_sat > max_r) ? combo_sat : max_r;
            if (&resolved_n) state_n = OVER;
         end
         OVER: begin
            if (bus.keycode == KEY_RESTART) begin
               state_n    = IDLE;
               resolved_n = '0;
               score_n    = '0;
               combo_n    = '0;
               max_n      = '0;
               hits_n     = '0;
               misses_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         hit_q    <= '0;
         done_q   <= '0;
         resolved <= '0;
         score_r  <= '0;
         combo_r  <= '0;
         max_r    <= '0;
         hits_r   <= '0;
         misses_r <= '0;
         over_r   <= 1'b0;
      end else begin
         state    <= state_n;
         hit_q    <= bus.hit;
         done_q   <= bus.done;
         resolved <= resolved_n;
         score_r  <= score_n;
         combo_r  <= combo_n;
         max_r    <= max_n;
         hits_r   <= hits_n;
         misses_r <= misses_n;
         over_r   <= (state_n == OVER);
      end
   end

   assign bus.score     = score_r;
   assign bus.combo     = combo_r;
   assign bus.max_combo = max_r;
   assign bus.hits      = hits_r;
   assign bus.misses    = misses_r;
   assign bus.game_over = over_r;
endmodule

// File: tb/tb_drop_score_tally.sv
// tb/tb_drop_score_tally.sv - directed and random checks of drop_score_tally against a score model
module tb_drop_score_tally;
   localparam int N_LANES    = 16;
   localparam int SCORE_W    = 16;
   localparam int CNT_W      = 8;
   localparam int HIT_POINTS = 100;
   localparam int SCORE_MAX  = 65535;
   localparam int CNT_MAX    = 255;
`ifdef COMBO_BONUS_EN
   localparam bit BONUS = 1'b1;
`else
   localparam bit BONUS = 1'b0;
`endif

   logic frame_clk = 1'b0;
   logic Reset_n   = 1'b0;

   drop_score_tally_if #(.N_LANES(N_LANES), .SCORE_W(SCORE_W), .CNT_W(CNT_W)) bus ();

   drop_score_tally #(
      .N_LANES(N_LANES), .SCORE_W(SCORE_W), .CNT_W(CNT_W), .HIT_POINTS(HIT_POINTS)
   ) dut (
      .frame_clk(frame_clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 frame_clk = ~frame_clk;

   int checks = 0;
   int errors = 0;

   // Game model: 0 = waiting for start, 1 = playing, 2 = finished
   int         m_phase;
   bit [15:0]  m_prev_h, m_prev_d, m_counted;
   int         m_score, m_combo, m_max, m_hits, m_misses;

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_clear();
      m_counted = '0;
      m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_misses = 0;
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_prev_h = '0;
      m_prev_d = '0;
      model_clear();
   endtask

   task automatic model_step(input logic [7:0] k, input bit [15:0] h, input bit [15:0] d);
      int nh, nm, per_hit;
      nh = 0;
      nm = 0;
      if (m_phase == 0) begin
         model_clear();
         if (k == 8'h2c) m_phase = 1;
      end else if (m_phase == 1) begin
         for (int i = 0; i < N_LANES; i++) begin
            if (!m_counted[i] && h[i] && !m_prev_h[i]) begin
               nh++;
               m_counted[i] = 1'b1;
            end else if (!m_counted[i] && d[i] && !m_prev_d[i] && !h[i]) begin
               nm++;
               m_counted[i] = 1'b1;
            end
         end
         per_hit  = (BONUS && m_combo >= 10) ? 2 * HIT_POINTS : HIT_POINTS;
         m_score  = min_i(m_score + nh * per_hit, SCORE_MAX);
         m_hits   = min_i(m_hits + nh, CNT_MAX);
         m_misses = min_i(m_misses + nm, CNT_MAX);
         m_combo  = (nm > 0) ? min_i(nh, CNT_MAX) : min_i(m_combo + nh, CNT_MAX);
         if (m_combo > m_max) m_max = m_combo;
         if (m_counted == 16'hffff) m_phase = 2;
      end else begin
         if (k == 8'h01) begin
            m_phase = 0;
            model_clear();
         end
      end
      m_prev_h = h;
      m_prev_d = d;
   endtask

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".score"},     int'(bus.score),     m_score);
      check_val({tag, ".combo"},     int'(bus.combo),     m_combo);
      check_val({tag, ".max_combo"}, int'(bus.max_combo), m_max);
      check_val({tag, ".hits"},      int'(bus.hits),      m_hits);
      check_val({tag, ".misses"},    int'(bus.misses),    m_misses);
      check_val({tag, ".game_over"}, int'(bus.game_over), (m_phase == 2) ? 1 : 0);
   endtask

   task automatic cycle(input logic [7:0] k, input bit [15:0] h, input bit [15:0] d, input string tag);
      bus.keycode = k;
      bus.hit     = h;
      bus.done    = d;
      model_step(k, h, d);
      @(posedge frame_clk);
      @(negedge frame_clk);
      check_all(tag);
   endtask

   // Reset is dropped between edges and checked before any clock arrives.
   task automatic do_reset(input string tag);
      bus.keycode = 8'h00;
      bus.hit     = '0;
      bus.done    = '0;
      Reset_n     = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge frame_clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      bit [15:0]  h, d, tog;
      logic [7:0] k;
      int         sel;

      bus.keycode = 8'h00;
      bus.hit     = '0;
      bus.done    = '0;
      model_reset();
      @(negedge frame_clk);
      @(negedge frame_clk);
      check_all("reset");
      Reset_n = 1'b1;

      // Lane 3 hit and done rise together: a hit only
      h = '0; d = '0;
      cycle(8'h2c, h, d, "start");
      h[3] = 1'b1; d[3] = 1'b1;
      cycle(8'h00, h, d, "hit_done_same");
      check_val("plan1.hits", int'(bus.hits), 1);
      check_val("plan1.score", int'(bus.score), 100);

      // Misses on lanes 0..4 then a hit on lane 5
      do_reset("rst_a");
      h = '0; d = '0;
      cycle(8'h2c, h, d, "start_b");
      d = 16'h001f;
      cycle(8'h00, h, d, "miss0_4");
      h[5] = 1'b1;
      cycle(8'h00, h, d, "hit5");
      check_val("plan2.misses", int'(bus.misses), 5);
      check_val("plan2.combo", int'(bus.combo), 1);

      // Combo 4, then two hits and a miss in one cycle
      do_reset("rst_b");
      h = '0; d = '0;
      cycle(8'h2c, h, d, "start_c");
      for (int i = 8; i < 12; i++) begin
         h[i] = 1'b1;
         cycle(8'h00, h, d, "combo_build");
      end
      h[1] = 1'b1; h[2] = 1'b1; d[7] = 1'b1;
      cycle(8'h00, h, d, "mixed_cycle");
      check_val("plan3.combo", int'(bus.combo), 2);
      check_val("plan3.max_combo", int'(bus.max_combo), 4);

      // Lane 12 hit toggles: counted once
      h[12] = 1'b1; cycle(8'h00, h, d, "tog1");
      h[12] = 1'b0; cycle(8'h00, h, d, "tog0");
      h[12] = 1'b1; cycle(8'h00, h, d, "tog1b");
      check_val("plan4.hits", int'(bus.hits), 7);

      // Resolve the remaining lanes, hold, restart
      d = d | 16'h0079;
      cycle(8'h00, h, d, "resolve_a");
      h[13] = 1'b1; h[14] = 1'b1; d[15] = 1'b1;
      cycle(8'h00, h, d, "resolve_last");
      check_val("plan5.game_over", int'(bus.game_over), 1);
      cycle(8'h2c, ~h, ~d, "over_hold");
      cycle(8'h01, h, d, "restart");
      check_val("plan5.score_clr", int'(bus.score), 0);
      check_val("plan5.game_over_clr", int'(bus.game_over), 0);

      // Random play with sparse toggles and occasional keys
      h = '0; d = '0;
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      k = 8'h2c;
         else if (sel == 1) k = 8'h01;
         else if (sel == 2) k = 8'($urandom_range(0, 255));
         else               k = 8'h00;
         tog = 16'($urandom & $urandom & $urandom);
         h = h ^ tog;
         tog = 16'($urandom & $urandom & $urandom);
         d = d ^ tog;
         cycle(k, h, d, "random");
      end

      // Twelve sequential hits, then an asynchronous reset mid-game
      do_reset("rst_c");
      h = '0; d = '0;
      cycle(8'h2c, h, d, "start_d");
      for (int i = 0; i < 12; i++) begin
         h[i] = 1'b1;
         cycle(8'h00, h, d, "seq_hit");
      end
      check_val("plan6.score", int'(bus.score), BONUS ? 1400 : 1200);
      h[12] = 1'b1;
      cycle(8'h00, h, d, "seq_hit13");
      do_reset("mid_reset");
      check_val("plan7.score", int'(bus.score), 0);
      cycle(8'h00, h, d, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/drop_score_tally.md
# drop_score_tally

Score collector at the receiving end of the droppers' hit/resolve outputs. It watches up to N_LANES lanes of per-note `hit` and `done` levels, edge-detects them, and counts each note exactly once as either a hit or a miss. It maintains saturating score, current combo, max combo, hit and miss counters, and raises `game_over` once every lane has resolved. It sits between the dropper array and the HUD/text renderer and uses the same start (0x2c) and restart (0x01) keycodes as the droppers.

## Interface
- N_LANES, 16, number of dropper lanes
- SCORE_W, 16, width of score output
- CNT_W, 8, width of combo, max combo, hit and miss counters
- HIT_POINTS, 100, points added per hit
- frame_clk  in  1  frame-rate clock; everything is sampled on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- keycode  in  8  primary keyboard keycode
- hit  in  N_LANES  per-lane level; high while that lane's note is scored as hit
- done  in  N_LANES  per-lane level; high once that lane's note has left play, by hit or by passing Y_Max
- score  out  SCORE_W  accumulated points, saturating
- combo  out  CNT_W  consecutive hits since last miss, saturating
- max_combo  out  CNT_W  largest combo reached this game
- hits  out  CNT_W  notes hit, saturating
- misses  out  CNT_W  notes missed, saturating
- game_over  out  1  high in OVER state

## Operation
- States: IDLE, PLAY, OVER.
  - IDLE to PLAY on keycode == 8'h2c.
  - PLAY to OVER when the resolved mask becomes all ones.
  - OVER to IDLE on keycode == 8'h01.
  - A keycode that does not match in the current state is ignored.
- IDLE clears score, combo, max_combo, hits, misses and the resolved mask every cycle.
- hit_q and done_q register `hit` and `done` in every state. A level already high when PLAY is entered is never counted.
- Per-cycle terms in PLAY:
  - rise_h = hit & ~hit_q & ~resolved
  - rise_d = done & ~done_q & ~resolved
  - new_hit = rise_h
  - new_miss = rise_d & ~hit
- A lane with both `hit` and `done` rising in the same cycle counts as a hit only.
- resolved |= new_hit | new_miss. A lane counts at most once per game.
- nh = popcount(new_hit) and nm = popcount(new_miss), each of width clog2(N_LANES+1).
- Updates in PLAY:
  - hits += nh
  - misses += nm
  - if nm != 0: combo = nh (misses in a cycle are ordered before hits in that cycle)
  - else: combo += nh
  - max_combo = max(max_combo, new combo)
  - score += nh*HIT_POINTS
- All arithmetic is computed one bit wider than the target and clamped to the all-ones value.
- In OVER, every counter holds its value; inputs are ignored apart from the restart key.

## Timing
- All outputs are registered.
- Reset values: score=0, combo=0, max_combo=0, hits=0, misses=0, game_over=0; state=IDLE; hit_q, done_q and resolved are all zero.
- Reset_n asserted mid-game: everything returns immediately to the reset values and IDLE.
- Latency: a rising input sampled at edge k is reflected on the outputs after edge k (one frame).
- game_over rises on the edge that completes the resolved mask; that edge's counter update is included.
- Simultaneous events on several lanes in one cycle are all counted in that same cycle; there is no arbitration and nothing is dropped.

## Configuration
- COMBO_BONUS_EN defined: if combo at the start of the cycle is at least 10, each hit in that cycle scores 2*HIT_POINTS instead of HIT_POINTS. Saturation rules are unchanged.
- COMBO_BONUS_EN undefined: every hit scores HIT_POINTS, and no bonus logic is synthesised.

## Structure
- Package `rhythm_pkg` holds:
  - the state enum {IDLE, PLAY, OVER}
  - KEY_START = 8'h2c and KEY_RESTART = 8'h01
  - COMBO_BONUS_THRESH = 10
- Sub-module `lane_popcount`: parameterised N_LANES-input population count, purely combinational, instantiated twice (nh, nm).

## Test plan
- Reset, then keycode 0x2c, then hit[3] and done[3] rising together → hits=1, misses=0, score=100, combo=1 one cycle later.
- In PLAY, done[0..4] rise with hit low, then hit[5] → misses=5, combo=1, max_combo=1, score=100.
- Same cycle: hit[1], hit[2] and a miss on lane 7, with combo previously 4 → combo=2, max_combo=4, hits incremented by 2, misses incremented by 1.
- A single lane whose hit toggles 0→1→0→1 → counted once; hits=1.
- Resolve all 16 lanes across several cycles, then send 0x01 → game_over=1 after the final edge with counters held; after 0x01, all outputs are 0 and the state is IDLE.
- With COMBO_BONUS_EN defined: 12 sequential hits → score=10*100+2*200=1400. Without the macro: score=1200. Assert Reset_n low mid-sequence → all outputs read 0 immediately.
